// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered result and flags.
//
// Single-cycle operations commit on the edge after an accepted Start. Shifts
// with a nonzero amount walk one bit position per cycle, and MUL runs a
// shift-add loop for WIDTH cycles. Busy is high while either multi-cycle
// sequence is running. The control unit stalls the PC on Busy.
//
// Ports:
//   Clk       rising-edge clock
//   Reset     synchronous, active-high reset
//   Start     request, sampled only while Busy=0
//   OP        opcode (0 ADD, 1 SUB, 2 AND, 3 XOR, 4 RXOR, 5 RSH1,
//             6 SHL, 7 SHR, 8 MUL, 9-15 NOP)
//   InputA    operand A
//   InputB    operand B; the low SHW bits give the shift amount
//   Busy      high while a multi-cycle op is in progress
//   Done      one-cycle pulse when Out and the flags are updated
//   Out       registered result, held until the next Done
//   Zero      registered flag, Out==0
//   Carry     registered carry/borrow/overflow/shifted-out flag
//   Negative  registered flag, Out[WIDTH-1]
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative
);

    // The counter must be able to hold WIDTH, which is the MUL iteration count.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_RXOR = 4'd4;
    localparam logic [3:0] OP_RSH1 = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MULT  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     work_reg, work_next;      // shift working value
    logic                 dir_left_reg, dir_left_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   prod_reg, prod_next;      // {partial high, multiplier remainder}
    logic [WIDTH-1:0]     mcand_reg, mcand_next;

    logic [WIDTH-1:0]     out_reg, out_next;
    logic                 zero_reg, zero_next;
    logic                 carry_reg, carry_next;
    logic                 neg_reg, neg_next;
    logic                 done_reg, done_next;

    logic                 commit;
    logic [WIDTH-1:0]     res;
    logic                 res_c;
    logic                 shift_out;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       mul_sum;

    assign add_full = {1'b0, InputA} + {1'b0, InputB};
    // Bit WIDTH of the extended difference is the unsigned borrow.
    assign sub_full = {1'b0, InputA} - {1'b0, InputB};
    assign shamt    = InputB[SHW-1:0];
    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB) is set. The whole product then shifts right.
    assign mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                    + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});

    always_comb begin
        state_next    = state_reg;
        work_next     = work_reg;
        dir_left_next = dir_left_reg;
        cnt_next      = cnt_reg;
        prod_next     = prod_reg;
        mcand_next    = mcand_reg;
        commit        = 1'b0;
        res           = '0;
        res_c         = 1'b0;
        shift_out     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    commit = 1'b1;
                    case (OP)
                        OP_ADD: begin
                            res   = add_full[WIDTH-1:0];
                            res_c = add_full[WIDTH];
                        end
                        OP_SUB: begin
                            res   = sub_full[WIDTH-1:0];
                            res_c = sub_full[WIDTH];
                        end
                        OP_AND:  res = InputA & InputB;
                        OP_XOR:  res = InputA ^ InputB;
                        OP_RXOR: res = {{(WIDTH-1){1'b0}}, ^InputA};
                        OP_RSH1: begin
                            res   = {1'b0, InputA[WIDTH-1:1]};
                            res_c = InputA[0];
                        end
                        OP_SHL, OP_SHR: begin
                            if (shamt == '0) begin
                                res = InputA;
                            end else begin
                                commit        = 1'b0;
                                state_next    = SHIFT;
                                work_next     = InputA;
                                cnt_next      = CW'(shamt);
                                dir_left_next = (OP == OP_SHL);
                            end
                        end
                        OP_MUL: begin
                            commit     = 1'b0;
                            state_next = MULT;
                            prod_next  = {{WIDTH{1'b0}}, InputB};
                            mcand_next = InputA;
                            cnt_next   = CW'(WIDTH);
                        end
                        default: res = '0;   // NOP opcodes
                    endcase
                end
            end

            SHIFT: begin
                if (dir_left_reg) begin
                    work_next = {work_reg[WIDTH-2:0], 1'b0};
                    shift_out = work_reg[WIDTH-1];
                end else begin
                    work_next = {1'b0, work_reg[WIDTH-1:1]};
                    shift_out = work_reg[0];
                end
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    commit     = 1'b1;
                    res        = work_next;
                    res_c      = shift_out;
                    state_next = IDLE;
                end
            end

            MULT: begin
                prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    commit     = 1'b1;
                    res        = prod_next[WIDTH-1:0];
                    res_c      = |prod_next[2*WIDTH-1:WIDTH];
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        out_next   = out_reg;
        zero_next  = zero_reg;
        carry_next = carry_reg;
        neg_next   = neg_reg;
        done_next  = 1'b0;
        if (commit) begin
            out_next   = res;
            zero_next  = (res == '0);
            carry_next = res_c;
            neg_next   = res[WIDTH-1];
            done_next  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            dir_left_reg <= 1'b0;
            cnt_reg      <= '0;
            prod_reg     <= '0;
            mcand_reg    <= '0;
            out_reg      <= '0;
            zero_reg     <= 1'b1;
            carry_reg    <= 1'b0;
            neg_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            work_reg     <= work_next;
            dir_left_reg <= dir_left_next;
            cnt_reg      <= cnt_next;
            prod_reg     <= prod_next;
            mcand_reg    <= mcand_next;
            out_reg      <= out_next;
            zero_reg     <= zero_next;
            carry_reg    <= carry_next;
            neg_reg      <= neg_next;
            done_reg     <= done_next;
        end
    end

    assign Busy     = (state_reg != IDLE);
    assign Done     = done_reg;
    assign Out      = out_reg;
    assign Zero     = zero_reg;
    assign Carry    = carry_reg;
    assign Negative = neg_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=8).
// Stimulus pushes the expected result and the expected Done cycle into a
// scoreboard queue. A monitor on the falling edge pops one entry for every
// Done pulse and compares the entry against the outputs.
module tb_seq_alu;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] OP;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       Busy;
    logic       Done;
    logic [7:0] Out;
    logic       Zero;
    logic       Carry;
    logic       Negative;

    seq_alu #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP),
        .InputA(InputA), .InputB(InputB),
        .Busy(Busy), .Done(Done), .Out(Out),
        .Zero(Zero), .Carry(Carry), .Negative(Negative)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] out;
        logic       z;
        logic       c;
        logic       n;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest scoreboard entry.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn cyc=%0d out=0x%02h z=%0b c=%0b n=%0b", cyc, Out, Zero, Carry, Negative);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("out", 32'(Out), 32'(e.out));
                chk("zero", 32'(Zero), 32'(e.z));
                chk("carry", 32'(Carry), 32'(e.c));
                chk("negative", 32'(Negative), 32'(e.n));
            end
        end
    end

    // Issue one op at the current cycle T and return in its Done cycle T+lat.
    // Busy must be high for T+1..T+lat-1 and low in the Done cycle.
    task automatic go(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int lat, input logic [7:0] eo,
                      input logic ez, input logic ec, input logic en);
        exp_t e;
        e.cyc = cyc + lat;
        e.out = eo;
        e.z   = ez;
        e.c   = ec;
        e.n   = en;
        sb.push_back(e);
        OP     = op;
        InputA = a;
        InputB = b;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start  = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk("busy_mid", 32'(Busy), 32'd1);
            @(posedge Clk); #1;
        end
        chk("busy_done_cycle", 32'(Busy), 32'd0);
    endtask

    initial begin
        Reset  = 1'b1;
        Start  = 1'b0;
        OP     = 4'd0;
        InputA = 8'h00;
        InputB = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_out", 32'(Out), 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_carry", 32'(Carry), 32'd0);
        chk("rst_neg", 32'(Negative), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);

        //  op     A      B      lat  out    Z     C     N
        go(4'd0, 8'hF0, 8'h20, 1, 8'h10, 1'b0, 1'b1, 1'b0);  // ADD carry out
        go(4'd1, 8'h05, 8'h05, 1, 8'h00, 1'b1, 1'b0, 1'b0);  // SUB equal
        go(4'd1, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b1, 1'b1);  // SUB borrow
        go(4'd8, 8'h0D, 8'h0B, 9, 8'h8F, 1'b0, 1'b0, 1'b1);  // MUL 13*11=143
        go(4'd8, 8'h20, 8'h10, 9, 8'h00, 1'b1, 1'b1, 1'b0);  // MUL 0x200
        go(4'd6, 8'h81, 8'h03, 4, 8'h08, 1'b0, 1'b0, 1'b0);  // SHL 3
        go(4'd7, 8'h81, 8'h01, 2, 8'h40, 1'b0, 1'b1, 1'b0);  // SHR 1
        go(4'd6, 8'h81, 8'h00, 1, 8'h81, 1'b0, 1'b0, 1'b1);  // SHL 0
        go(4'd2, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0, 1'b0);  // AND
        go(4'd3, 8'hFF, 8'h0F, 1, 8'hF0, 1'b0, 1'b0, 1'b1);  // XOR
        go(4'd4, 8'h07, 8'h00, 1, 8'h01, 1'b0, 1'b0, 1'b0);  // RXOR odd parity
        go(4'd5, 8'h81, 8'h00, 1, 8'h40, 1'b0, 1'b1, 1'b0);  // RSH1
        go(4'd7, 8'h80, 8'h07, 8, 8'h01, 1'b0, 1'b0, 1'b0);  // SHR 7
        go(4'd6, 8'h03, 8'h0F, 8, 8'h80, 1'b0, 1'b1, 1'b1);  // SHL 7, B upper bits ignored
        go(4'd9, 8'hFF, 8'hFF, 1, 8'h00, 1'b1, 1'b0, 1'b0);  // NOP
        go(4'd0, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 1'b0);  // ADD wrap
        go(4'd15, 8'h12, 8'h34, 1, 8'h00, 1'b1, 1'b0, 1'b0); // NOP

        // Start during MUL is ignored; Start in the Done cycle is accepted.
        begin
            exp_t e;
            e.cyc = cyc + 9; e.out = 8'h8F; e.z = 1'b0; e.c = 1'b0; e.n = 1'b1;
            sb.push_back(e);
            OP = 4'd8; InputA = 8'h0D; InputB = 8'h0B; Start = 1'b1;
            @(posedge Clk); #1; Start = 1'b0;                   // T+1
            repeat (2) begin @(posedge Clk); #1; end            // T+3
            OP = 4'd0; InputA = 8'h01; InputB = 8'h01; Start = 1'b1;
            @(posedge Clk); #1; Start = 1'b0;                   // T+4
            chk("busy_ignore", 32'(Busy), 32'd1);
            repeat (5) begin @(posedge Clk); #1; end            // T+9, Done cycle
            e.cyc = cyc + 1; e.out = 8'h02; e.z = 1'b0; e.c = 1'b0; e.n = 1'b0;
            sb.push_back(e);
            OP = 4'd0; InputA = 8'h01; InputB = 8'h01; Start = 1'b1;
            @(posedge Clk); #1; Start = 1'b0;                   // T+10
        end

        // Reset together with Start: Start is dropped.
        @(posedge Clk); #1;
        Reset = 1'b1; Start = 1'b1; OP = 4'd0; InputA = 8'h01; InputB = 8'h01;
        @(posedge Clk); #1;
        Reset = 1'b0; Start = 1'b0;
        chk("rst_start_busy", 32'(Busy), 32'd0);
        chk("rst_start_out", 32'(Out), 32'd0);
        @(posedge Clk); #1;
        chk("rst_start_done", 32'(Done), 32'd0);

        // Establish a nonzero Out, then abort a MUL with reset at T+4.
        go(4'd0, 8'h01, 8'h01, 1, 8'h02, 1'b0, 1'b0, 1'b0);
        OP = 4'd8; InputA = 8'hFF; InputB = 8'hFF; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;                       // T+1
        repeat (3) begin @(posedge Clk); #1; end                // T+4
        chk("abort_busy_before", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;                                     // T+5
        Reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_out", 32'(Out), 32'd0);
        chk("abort_zero", 32'(Zero), 32'd1);
        repeat (12) @(posedge Clk);                             // monitor flags any stray Done

        begin
            int guard = 0;
            while (sb.size() != 0 && guard < 50) begin
                @(posedge Clk);
                guard++;
            end
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Adds registered results and flags (Zero, Carry, Negative), plus multi-cycle operations: variable shift and iterative multiply.
- Uses a Start/Busy/Done handshake.
- Sits between the register file read ports and the writeback mux; the control unit stalls the PC while Busy is high.

Parameters:
- WIDTH, 8: datapath width in bits (at least 4).
- SHW, $clog2(WIDTH): width of the shift-amount field taken from InputB.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request. Sampled only while Busy=0.
- OP  input  4  opcode, latched on an accepted Start.
- InputA  input  WIDTH  operand A, latched on an accepted Start.
- InputB  input  WIDTH  operand B, latched on an accepted Start.
- Busy  output  1  high while a multi-cycle op is in progress.
- Done  output  1  one-cycle pulse when Out and the flags are updated.
- Out  output  WIDTH  registered result. Held until the next Done.
- Zero  output  1  registered flag: Out==0.
- Carry  output  1  registered carry/borrow/overflow flag (per-op rules below).
- Negative  output  1  registered flag: Out[WIDTH-1].

Behaviour:
- Opcodes (OP value, operation, Carry rule):
  - 0 ADD: A+B. Carry = carry-out.
  - 1 SUB: A-B. Carry = borrow, i.e. 1 when A<B unsigned.
  - 2 AND: A&B. Carry = 0.
  - 3 XOR: A^B. Carry = 0.
  - 4 RXOR: zero-extended ^A. Carry = 0.
  - 5 RSH1: logical right shift of A by 1. Carry = A[0].
  - 6 SHL: logical left shift of A by n = B[SHW-1:0]. Carry = last bit shifted out, 0 if n=0.
  - 7 SHR: logical right shift of A by n = B[SHW-1:0]. Carry = last bit shifted out, 0 if n=0.
  - 8 MUL: low WIDTH bits of A*B, unsigned. Carry = 1 if the high WIDTH bits are nonzero.
  - 9-15: NOP. Out = 0, Carry = 0, Zero = 1. Completes like a single-cycle op.
- State machine: IDLE, SHIFT, MULT.
  - IDLE, Start=1, single-cycle op (0-5, 9-15) or shift with n=0: result committed at the next edge. Done=1 in cycle T+1. Stays in IDLE.
  - IDLE, Start=1, SHL/SHR with n>0: go to SHIFT. Busy=1. One bit position per cycle for n cycles. Commit and Done at T+1+n. Busy falls in the same cycle Done rises.
  - IDLE, Start=1, MUL: go to MULT. Busy=1. Shift-add, one multiplier bit per cycle, for exactly WIDTH cycles. Commit and Done at T+1+WIDTH.
- Busy is combinationally derived from state (high in SHIFT and MULT). Done is a registered pulse.
- Start while Busy=1 is ignored. Operands and OP must not be re-latched.
- Start in the Done cycle (state IDLE) is accepted, giving back-to-back operation.
- Out, Zero, Carry and Negative change only on the Done edge. Intermediate shift/product registers are internal.
- Arithmetic is unsigned modulo 2^WIDTH. The MUL accumulator is 2*WIDTH bits wide.
- Reset: Out=0, Zero=1, Carry=0, Negative=0, Busy=0, Done=0, state=IDLE. Internal counters and accumulators are cleared.
- Reset asserted mid-operation aborts the op. No Done is produced, and outputs take their reset values at the next edge.
- Reset and Start together: Reset wins and Start is dropped.

Test Plan (WIDTH=8):
- Reset, then ADD with A=0xF0, B=0x20 at cycle T -> Done at T+1; Out=0x10, Carry=1, Zero=0, Negative=0.
- SUB 0x05-0x05 -> Out=0x00, Zero=1, Carry=0. Then SUB 0x03-0x05 -> Out=0xFE, Carry=1, Negative=1. Each has Done one cycle after Start.
- MUL 0x0D*0x0B at T -> Busy high T+1..T+8, Done at T+9, Out=0x8F, Carry=0. MUL 0x20*0x10 -> Out=0x00, Zero=1, Carry=1.
- SHL A=0x81, B=3 -> Done at T+4, Out=0x08, Carry=0. SHR A=0x81, B=1 -> Done at T+2, Out=0x40, Carry=1. SHL with B=0 -> Done at T+1, Out=0x81, Carry=0.
- Start with ADD 1+1 pulsed at T+3 during a MUL -> ignored; MUL result unchanged at T+9. ADD issued in the Done cycle -> Out=0x02 at T+10.
- Reset asserted at T+4 of a MUL -> next cycle Busy=0, Done=0, Out=0, Zero=1. No Done pulse follows.
